// File: rtl/vga_box_painter_pkg.sv
// rtl/vga_box_painter_pkg.sv - shared constants and types for the VGA box painter
// Holds the active-area defaults, pixel/direction types and the colour-bar table.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef enum logic {MOVE_POS, MOVE_NEG} dir_e;

   // Left-to-right bar colours
   localparam logic [11:0] BAR_COLORS [8] = '{
      12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
      12'hF0F, 12'hF00, 12'h00F, 12'h000
   };

endpackage

// File: rtl/vga_box_painter_box_axis.sv
// rtl/vga_box_painter_box_axis.sv - one bouncing axis: position register plus direction FSM
// Moves by STEP per step_en and reverses when it reaches 0 or LIMIT.
module box_axis
   import vga_pkg::*;
#(
   parameter int LIMIT = 608,
   parameter int STEP  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step_en,
   output logic [9:0] pos
);

   localparam logic [10:0] LIM11  = 11'(LIMIT);
   localparam logic [10:0] STEP11 = 11'(STEP);
   localparam logic [9:0]  STEP10 = 10'(STEP);

   dir_e        state, state_next;
   logic [9:0]  pos_next;
   logic [10:0] sum;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MOVE_POS;
         pos   <= '0;
      end else begin
         state <= state_next;
         pos   <= pos_next;
      end
   end

   // 11-bit sum so a step past the limit cannot wrap back below it
   always_comb begin
      state_next = state;
      pos_next   = pos;
      sum        = {1'b0, pos} + STEP11;
      if (step_en) begin
         case (state)
            MOVE_POS: begin
               if (sum >= LIM11) begin
                  pos_next   = LIM11[9:0];
                  state_next = MOVE_NEG;
               end else begin
                  pos_next = sum[9:0];
               end
            end
            MOVE_NEG: begin
               if ({1'b0, pos} <= STEP11) begin
                  pos_next   = '0;
                  state_next = MOVE_POS;
               end else begin
                  pos_next = pos - STEP10;
               end
            end
            default: state_next = MOVE_POS;
         endcase
      end
   end

endmodule

// File: rtl/vga_box_painter.sv
// rtl/vga_box_painter.sv - two-stage pixel pipeline drawing a bouncing square
// Define VGA_BOX_PAINTER_BARS_EN for a colour-bar background instead of BG_COLOR.
module vga_box_painter
   import vga_pkg::*;
#(
   parameter int          H_ACTIVE  = H_ACTIVE_DEF,
   parameter int          V_ACTIVE  = V_ACTIVE_DEF,
   parameter int          BOX_SIZE  = 32,
   parameter int          STEP      = 2,
   parameter logic [11:0] BOX_COLOR = 12'hF00,
   parameter logic [11:0] BG_COLOR  = 12'h00F
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [9:0] xcounter,
   input  logic [9:0] ycounter,
   input  logic       h_sync_in,
   input  logic       v_sync_in,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       vga_h_sync,
   output logic       vga_v_sync,
   output logic       frame_tick
);

   localparam logic [10:0] HA11 = 11'(H_ACTIVE);
   localparam logic [10:0] VA11 = 11'(V_ACTIVE);
   localparam logic [10:0] BS11 = 11'(BOX_SIZE);

   logic [9:0]  box_x, box_y;
   logic [10:0] x11, y11, bx11, by11;
   logic        upd;
   logic        s1_active, s1_in_box, s1_hs, s1_vs;
   logic [11:0] s1_bg;
   rgb444_t     pix;

   assign x11  = {1'b0, xcounter};
   assign y11  = {1'b0, ycounter};
   assign bx11 = {1'b0, box_x};
   assign by11 = {1'b0, box_y};

   // First blanking pixel after the last visible one
   assign upd = (x11 == HA11) && (y11 == VA11 - 11'd1);

   box_axis #(.LIMIT(H_ACTIVE - BOX_SIZE), .STEP(STEP)) u_x (
      .clk     (clk),
      .reset   (reset),
      .step_en (upd && enable),
      .pos     (box_x)
   );

   box_axis #(.LIMIT(V_ACTIVE - BOX_SIZE), .STEP(STEP)) u_y (
      .clk     (clk),
      .reset   (reset),
      .step_en (upd && enable),
      .pos     (box_y)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_active <= 1'b0;
         s1_in_box <= 1'b0;
         s1_hs     <= 1'b0;
         s1_vs     <= 1'b0;
      end else begin
         s1_active <= (x11 < HA11) && (y11 < VA11);
         s1_in_box <= (x11 >= bx11) && (x11 < bx11 + BS11) &&
                      (y11 >= by11) && (y11 < by11 + BS11);
         s1_hs     <= h_sync_in;
         s1_vs     <= v_sync_in;
      end
   end

`ifdef VGA_BOX_PAINTER_BARS_EN
   logic [2:0] bar_idx;
   assign bar_idx = 3'(xcounter / 10'(H_ACTIVE / 8));

   // Bar colour travels with stage 1 so latency matches the plain build
   always_ff @(posedge clk) begin
      if (reset) s1_bg <= '0;
      else       s1_bg <= BAR_COLORS[bar_idx];
   end
`else
   assign s1_bg = BG_COLOR;
`endif

   always_comb begin
      pix = '0;
      if (s1_active) pix = s1_in_box ? BOX_COLOR : s1_bg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vga_r      <= '0;
         vga_g      <= '0;
         vga_b      <= '0;
         vga_h_sync <= 1'b0;
         vga_v_sync <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         vga_r      <= pix.r;
         vga_g      <= pix.g;
         vga_b      <= pix.b;
         vga_h_sync <= s1_hs;
         vga_v_sync <= s1_vs;
         frame_tick <= upd;
      end
   end

endmodule

// File: tb/tb_vga_box_painter.sv
// tb/tb_vga_box_painter.sv - directed self-checking bench for vga_box_painter
// Expected values honour VGA_BOX_PAINTER_BARS_EN when it is defined.
module tb_vga_box_painter;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic [9:0] xcounter, ycounter;
   logic       h_sync_in, v_sync_in;
   logic [3:0] vga_r, vga_g, vga_b;
   logic       vga_h_sync, vga_v_sync, frame_tick;
   logic [3:0] c_r, c_g, c_b;
   logic       c_hs, c_vs, c_tick;

   int checks = 0;
   int errors = 0;
   int tick_cnt;

   always #5 clk = ~clk;

   vga_box_painter u_dut (
      .clk(clk), .reset(reset), .enable(enable),
      .xcounter(xcounter), .ycounter(ycounter),
      .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
      .frame_tick(frame_tick)
   );

   // Square active area so both axes hit their limits on the same update
   vga_box_painter #(.H_ACTIVE(480), .V_ACTIVE(480)) u_corner (
      .clk(clk), .reset(reset), .enable(1'b1),
      .xcounter(xcounter), .ycounter(ycounter),
      .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .vga_r(c_r), .vga_g(c_g), .vga_b(c_b),
      .vga_h_sync(c_hs), .vga_v_sync(c_vs),
      .frame_tick(c_tick)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_upd(input logic [9:0] ux);
      xcounter = ux;
      ycounter = (ux == 10'd640) ? 10'd479 : 10'd479;
      step();
      tick_cnt += int'(frame_tick);
      xcounter = 10'd0;
      ycounter = 10'd0;
      step();
      tick_cnt += int'(frame_tick);
   endtask

   function automatic logic [31:0] rgb();
      return {20'd0, vga_r, vga_g, vga_b};
   endfunction

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [11:0] exp;
   } pix_t;

`ifdef VGA_BOX_PAINTER_BARS_EN
   pix_t pix_tab[13] = '{
      '{10'd100, 10'd100, 12'hFF0}, '{10'd10, 10'd10, 12'hF00}, '{10'd700, 10'd10, 12'h000},
      '{10'd31, 10'd31, 12'hF00},   '{10'd32, 10'd31, 12'hFFF}, '{10'd31, 10'd32, 12'hFFF},
      '{10'd639, 10'd479, 12'h000}, '{10'd639, 10'd480, 12'h000}, '{10'd800, 10'd100, 12'h000},
      '{10'd0, 10'd0, 12'hF00},     '{10'd0, 10'd100, 12'hFFF}, '{10'd85, 10'd100, 12'hFF0},
      '{10'd639, 10'd100, 12'h000}
   };
   localparam logic [11:0] BG_AT_606 = 12'h000;
`else
   pix_t pix_tab[13] = '{
      '{10'd100, 10'd100, 12'h00F}, '{10'd10, 10'd10, 12'hF00}, '{10'd700, 10'd10, 12'h000},
      '{10'd31, 10'd31, 12'hF00},   '{10'd32, 10'd31, 12'h00F}, '{10'd31, 10'd32, 12'h00F},
      '{10'd639, 10'd479, 12'h00F}, '{10'd639, 10'd480, 12'h000}, '{10'd800, 10'd100, 12'h000},
      '{10'd0, 10'd0, 12'hF00},     '{10'd0, 10'd100, 12'h00F}, '{10'd85, 10'd100, 12'h00F},
      '{10'd639, 10'd100, 12'h00F}
   };
   localparam logic [11:0] BG_AT_606 = 12'h00F;
`endif

   initial begin
      reset = 1'b1; enable = 1'b0;
      xcounter = 10'd10; ycounter = 10'd10;
      h_sync_in = 1'b1; v_sync_in = 1'b1;
      repeat (3) step();
      check("reset_rgb", rgb(), 32'h0);
      check("reset_hs", {31'd0, vga_h_sync}, 32'd0);
      check("reset_vs", {31'd0, vga_v_sync}, 32'd0);
      check("reset_tick", {31'd0, frame_tick}, 32'd0);
      check("reset_box_x", {22'd0, u_dut.box_x}, 32'd0);

      h_sync_in = 1'b0; v_sync_in = 1'b0;
      reset = 1'b0;
      step();
      check("rgb_pipe_not_ready", rgb(), 32'h0);

      foreach (pix_tab[i]) begin
         xcounter = pix_tab[i].x;
         ycounter = pix_tab[i].y;
         step();
         step();
         check($sformatf("pix_%0d_%0d", pix_tab[i].x, pix_tab[i].y), rgb(), {20'd0, pix_tab[i].exp});
      end

      h_sync_in = 1'b1;
      step();
      check("hs_plus1", {31'd0, vga_h_sync}, 32'd0);
      step();
      check("hs_plus2", {31'd0, vga_h_sync}, 32'd1);
      h_sync_in = 1'b0;
      v_sync_in = 1'b1;
      step();
      check("vs_plus1", {31'd0, vga_v_sync}, 32'd0);
      check("hs_fall_plus1", {31'd0, vga_h_sync}, 32'd1);
      step();
      check("vs_plus2", {31'd0, vga_v_sync}, 32'd1);
      check("hs_fall_plus2", {31'd0, vga_h_sync}, 32'd0);
      v_sync_in = 1'b0;

      enable = 1'b1;
      tick_cnt = 0;
      do_upd(10'd640);
      check("pos_after1", {u_dut.box_x, u_dut.box_y}, {10'd2, 10'd2});
      for (int n = 2; n <= 224; n++) do_upd(10'd640);
      check("pos_y_limit", {u_dut.box_x, u_dut.box_y}, {10'd448, 10'd448});
      do_upd(10'd640);
      check("pos_y_reverse", {u_dut.box_x, u_dut.box_y}, {10'd450, 10'd446});
      for (int n = 226; n <= 304; n++) do_upd(10'd640);
      check("pos_x_limit", {u_dut.box_x, u_dut.box_y}, {10'd608, 10'd288});
      do_upd(10'd640);
      check("pos_x_reverse", {u_dut.box_x, u_dut.box_y}, {10'd606, 10'd286});
      check("tick_per_frame", tick_cnt, 32'd305);

      enable = 1'b0;
      tick_cnt = 0;
      repeat (3) do_upd(10'd640);
      check("frozen_pos", {u_dut.box_x, u_dut.box_y}, {10'd606, 10'd286});
      check("frozen_ticks", tick_cnt, 32'd3);

      xcounter = 10'd606; ycounter = 10'd286;
      step(); step();
      check("moved_box_corner", rgb(), 32'hF00);
      xcounter = 10'd605;
      step(); step();
      check("left_of_moved_box", rgb(), {20'd0, BG_AT_606});

      xcounter = 10'd606;
      h_sync_in = 1'b1;
      step(); step();
      check("pre_reset_rgb", rgb(), 32'hF00);
      reset = 1'b1;
      step();
      check("midline_reset_rgb", rgb(), 32'h0);
      check("midline_reset_hs", {31'd0, vga_h_sync}, 32'd0);
      check("midline_reset_pos", {u_dut.box_x, u_dut.box_y}, 20'd0);
      reset = 1'b0;
      h_sync_in = 1'b0;
      step();
      check("refill_1", rgb(), 32'h0);
      step();
      check("refill_2", rgb(), {20'd0, BG_AT_606});

      tick_cnt = 0;
      for (int n = 1; n <= 223; n++) do_upd(10'd480);
      check("corner_pre", {u_corner.box_x, u_corner.box_y}, {10'd446, 10'd446});
      do_upd(10'd480);
      check("corner_hit", {u_corner.box_x, u_corner.box_y}, {10'd448, 10'd448});
      do_upd(10'd480);
      check("corner_both_neg", {u_corner.box_x, u_corner.box_y}, {10'd446, 10'd446});
      check("main_idle_in_corner", {u_dut.box_x, u_dut.box_y}, 20'd0);
      check("main_ticks_in_corner", tick_cnt, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
